// File: rtl/dircc_msg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dircc_msg_pkg
// Purpose  : Shared state type, header layout and defaults for the RX DMA.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package dircc_msg_pkg;

    localparam logic [14:0] DEF_BASE_ADDR  = 15'h4000;
    localparam int          DEF_SLOT_WORDS = 32;
    localparam int          DEF_NUM_SLOTS  = 8;

    localparam int HDR_TRUNC_BIT = 15;
    localparam int HDR_LEN_MSB   = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HEADER  = 2'd2,
        ST_DROP    = 2'd3
    } rx_state_e;

    function automatic logic [15:0] make_header(input logic trunc,
                                                input logic [HDR_LEN_MSB:0] len);
        logic [15:0] h;
        h                  = '0;
        h[HDR_TRUNC_BIT]   = trunc;
        h[HDR_LEN_MSB:0]   = len;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dircc_msg_slot_ring.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dircc_msg_slot_ring
// Purpose  : Write-slot pointer, full-slot count and commit/release arbitration.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module dircc_msg_slot_ring
    import dircc_msg_pkg::*;
#(
    parameter  int NUM_SLOTS = DEF_NUM_SLOTS,
    localparam int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          commit,
    input  logic          rel,
    output logic [SW-1:0] wr_slot,
    output logic [4:0]    fill_count,
    output logic          full
);

    localparam logic [4:0] FILL_MAX = 5'(NUM_SLOTS);

    logic [SW-1:0] wr_slot_q, wr_slot_d;
    logic [4:0]    fill_q, fill_d;
    logic          commit_q;
    logic          inc, dec;

    // The slot pointer moves at once so a back-to-back packet lands in the
    // next slot; the count follows one cycle later with the header write.
    always_comb begin
        wr_slot_d = wr_slot_q;
        if (commit) begin
            wr_slot_d = wr_slot_q + SW'(1);
        end
        inc    = commit_q && (fill_q != FILL_MAX);
        dec    = rel && (fill_q != 5'd0);
        fill_d = fill_q;
        if (inc && !dec) begin
            fill_d = fill_q + 5'd1;
        end else if (dec && !inc) begin
            fill_d = fill_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_slot_q <= '0;
            fill_q    <= '0;
            commit_q  <= 1'b0;
        end else begin
            wr_slot_q <= wr_slot_d;
            fill_q    <= fill_d;
            commit_q  <= commit;
        end
    end

    // A commit still in flight already owns its slot.
    assign full       = (fill_q == FILL_MAX) ||
                        (commit_q && (fill_q == FILL_MAX - 5'd1));
    assign wr_slot    = wr_slot_q;
    assign fill_count = fill_q;

endmodule
`default_nettype wire

// File: rtl/dircc_msg_rx_dma.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dircc_msg_rx_dma
// Purpose  : Packet stream to slot-ring DMA; optional irq via DIRCC_MSG_RX_IRQ_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module dircc_msg_rx_dma
    import dircc_msg_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SLOT_WORDS = DEF_SLOT_WORDS,
    parameter int          NUM_SLOTS  = DEF_NUM_SLOTS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic [14:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic        mem_clken,
    output logic [15:0] mem_writedata,
    output logic [1:0]  mem_byteenable,
    input  logic        rel,
    output logic [4:0]  fill_count,
    output logic [15:0] drop_count,
    output logic        irq
);

    localparam int         SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [7:0] LAST_LEN = 8'(SLOT_WORDS - 1);

    rx_state_e     state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic          trunc_q, trunc_d;
    logic [15:0]   drop_q, drop_d;
    logic          in_ready_q, in_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [14:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;

    logic          accept;
    logic          commit;
    logic          ring_full;
    logic [SW-1:0] wr_slot;
    logic [14:0]   slot_base;

    assign accept    = in_valid && in_ready_q;
    assign commit    = (state_q == ST_HEADER);
    assign slot_base = BASE_ADDR + (15'(wr_slot) * 15'(SLOT_WORDS));

    dircc_msg_slot_ring #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_ring (
        .clk        (clk),
        .reset_n    (reset_n),
        .commit     (commit),
        .rel        (rel),
        .wr_slot    (wr_slot),
        .fill_count (fill_count),
        .full       (ring_full)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        drop_d      = drop_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && in_sop) begin
                    if (!ring_full) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = slot_base + 15'd1;
                        mem_wdata_d = in_data;
                        len_d       = 8'd1;
                        state_d     = in_eop ? ST_HEADER : ST_PAYLOAD;
                    end else begin
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                        if (!in_eop) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = slot_base + 15'd1 + 15'(len_q);
                    mem_wdata_d = in_data;
                    len_d       = len_q + 8'd1;
                    if (in_eop) begin
                        state_d = ST_HEADER;
                    end else if (len_d == LAST_LEN) begin
                        trunc_d = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (accept && in_eop) begin
                    state_d = trunc_q ? ST_HEADER : ST_IDLE;
                end
            end
            ST_HEADER: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = slot_base;
                mem_wdata_d = make_header(trunc_q, len_q);
                trunc_d     = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d != ST_HEADER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            drop_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            drop_q      <= drop_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign mem_address    = mem_addr_q;
    assign mem_chipselect = mem_we_q;
    assign mem_write      = mem_we_q;
    assign mem_clken      = mem_we_q;
    assign mem_writedata  = mem_wdata_q;
    assign mem_byteenable = 2'b11;
    assign drop_count     = drop_q;

`ifdef DIRCC_MSG_RX_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = (fill_count != 5'd0);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dircc_msg_rx_dma.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_dircc_msg_rx_dma
// Purpose  : Self-checking bench for the receive DMA at default parameters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_dircc_msg_rx_dma;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, rel = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, mem_chipselect, mem_write, mem_clken, irq;
    logic [14:0] mem_address;
    logic [15:0] mem_writedata, drop_count;
    logic [1:0]  mem_byteenable;
    logic [4:0]  fill_count;

    always #5 clk = ~clk;

    dircc_msg_rx_dma dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .rel(rel), .fill_count(fill_count), .drop_count(drop_count), .irq(irq)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { int c; logic [14:0] a; logic [15:0] d; } wr_t;
    wr_t         wlog[$];
    int          acc_cyc[$];
    logic [15:0] tbmem [0:32767];
    int          oob_writes = 0, bad_strobe = 0;
    int          fill_rise = -1, irq_rise = -1;
    logic        irq_seen = 1'b0, prev_irq = 1'b0;
    logic [4:0]  prev_fill = '0;
    logic [15:0] pkt [0:63];
    bit          gap_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (reset_n && in_valid && in_ready) acc_cyc.push_back(cyc);
        if (mem_write) begin
            w.c = cyc; w.a = mem_address; w.d = mem_writedata;
            wlog.push_back(w);
            tbmem[mem_address] = mem_writedata;
            if (mem_address < 15'h4000 || mem_address > 15'h40FF) oob_writes++;
        end
        if (mem_write !== mem_chipselect || mem_write !== mem_clken || mem_byteenable !== 2'b11)
            bad_strobe++;
        if (fill_count == 5'd1 && prev_fill == 5'd0) fill_rise = cyc;
        if (irq && !prev_irq) irq_rise = cyc;
        if (irq) irq_seen = 1'b1;
        prev_fill = fill_count;
        prev_irq  = irq;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; rel = 1'b0;
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic send_word(input logic [15:0] d, input logic s, input logic e);
        int guard = 0;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            wait_cycles($urandom_range(1, 2));
        end
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
        while (!in_ready && guard < 50) begin wait_cycles(1); guard++; end
        if (guard >= 50) begin
            total++; bad++;
            $display("FAIL ready wait: in_ready stuck low for %0d cycles", guard);
        end
        wait_cycles(1);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) send_word(pkt[i], i == 0, i == n - 1);
    endtask

    task automatic pulse_rel();
        rel = 1'b1; wait_cycles(1); rel = 1'b0;
    endtask

    typedef struct {
        int len; logic [15:0] d0; bit rel_before; bit check;
        int exp_fill; int exp_drop; int exp_slot; logic [15:0] exp_hdr;
    } vec_t;
    vec_t vt [11];

    initial begin
        int slot_ent [8];
        int exp_wr, idx, mism, n, stored, base;
        int m_fill, m_drop, m_slot;
        logic [15:0] hdr;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int slot_ent [8];
        int exp_wr, idx, mism, n, stored, base;
        int m_fill, m_drop, m_slot;
        logic [15:0] hdr;

        vt[0]  = '{3,  16'h1111, 1'b0, 1'b1, 1, 0, 0,  16'h0003};
        vt[1]  = '{1,  16'h00A0, 1'b0, 1'b1, 2, 0, 1,  16'h0001};
        vt[2]  = '{40, 16'h0100, 1'b0, 1'b1, 3, 0, 2,  16'h801F};
        vt[3]  = '{31, 16'h0200, 1'b0, 1'b1, 4, 0, 3,  16'h001F};
        vt[4]  = '{32, 16'h0300, 1'b0, 1'b1, 5, 0, 4,  16'h801F};
        vt[5]  = '{5,  16'h0400, 1'b0, 1'b1, 6, 0, 5,  16'h0005};
        vt[6]  = '{2,  16'h0500, 1'b0, 1'b1, 7, 0, 6,  16'h0002};
        vt[7]  = '{30, 16'h0600, 1'b0, 1'b0, 8, 0, 7,  16'h001E};
        vt[8]  = '{4,  16'h0700, 1'b0, 1'b1, 8, 1, -1, 16'h0000};
        vt[9]  = '{1,  16'h0800, 1'b0, 1'b1, 8, 2, -1, 16'h0000};
        vt[10] = '{3,  16'h0900, 1'b1, 1'b1, 8, 2, 0,  16'h0003};

        // Reset state, checked while reset is held.
        reset_n = 1'b0;
        wait_cycles(2);
        chk("reset in_ready", in_ready, 0);
        chk("reset mem_write", mem_write, 0);
        chk("reset fill", fill_count, 0);
        chk("reset drop", drop_count, 0);
        chk("reset irq", irq, 0);
        reset_n = 1'b1;
        wait_cycles(1);
        chk("ready after reset", in_ready, 1);

        // Latency of payload, header and fill for a 3-word packet.
        wlog.delete(); acc_cyc.delete(); fill_rise = -1; irq_rise = -1;
        pkt[0] = 16'h1111; pkt[1] = 16'h2222; pkt[2] = 16'h3333;
        send_pkt(3);
        wait_cycles(6);
        chk("lat accepts", acc_cyc.size(), 3);
        chk("lat writes", wlog.size(), 4);
        if (wlog.size() == 4 && acc_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("lat word cycle", wlog[i].c - acc_cyc[i], 1);
                chk("lat word addr", wlog[i].a, 15'h4001 + 15'(i));
                chk("lat word data", wlog[i].d, pkt[i]);
            end
            chk("lat hdr cycle", wlog[3].c - acc_cyc[2], 2);
            chk("lat hdr addr", wlog[3].a, 15'h4000);
            chk("lat hdr data", wlog[3].d, 16'h0003);
            chk("lat fill cycle", fill_rise - acc_cyc[2], 3);
        end
        chk("lat fill", fill_count, 1);
`ifdef DIRCC_MSG_RX_IRQ_EN
        chk("irq rise cycle", irq_rise - fill_rise, 1);
`endif

        // Table of packets from a fresh ring.
        do_reset();
        wlog.delete(); acc_cyc.delete();
        exp_wr = 0;
        idx = 0;
        for (int e = 0; e < 11; e++) begin
            if (vt[e].rel_before) begin pulse_rel(); wait_cycles(3); end
            for (int i = 0; i < vt[e].len; i++) pkt[i] = 16'(vt[e].d0 + 16'(i) * 16'h1111);
            if (e == 8) idx = acc_cyc.size();
            send_pkt(vt[e].len);
            if (vt[e].exp_slot >= 0) exp_wr += ((vt[e].len < 31) ? vt[e].len : 31) + 1;
            if (vt[e].check) begin
                wait_cycles(4);
                chk($sformatf("vec%0d fill", e), fill_count, vt[e].exp_fill);
                chk($sformatf("vec%0d drop", e), drop_count, vt[e].exp_drop);
                chk($sformatf("vec%0d writes", e), wlog.size(), exp_wr);
            end
            if (e == 8 && idx > 0 && acc_cyc.size() > idx)
                chk("bubble", acc_cyc[idx] - acc_cyc[idx - 1], 2);
        end
        for (int s = 0; s < 8; s++) slot_ent[s] = -1;
        for (int e = 0; e < 11; e++) if (vt[e].exp_slot >= 0) slot_ent[vt[e].exp_slot] = e;
        for (int s = 0; s < 8; s++) begin
            if (slot_ent[s] >= 0) begin
                base = 16'h4000 + s * 32;
                chk($sformatf("slot%0d header", s), tbmem[base], vt[slot_ent[s]].exp_hdr);
                mism = 0;
                stored = (vt[slot_ent[s]].len < 31) ? vt[slot_ent[s]].len : 31;
                for (int i = 0; i < stored; i++)
                    if (tbmem[base + 1 + i] !== 16'(vt[slot_ent[s]].d0 + 16'(i) * 16'h1111)) mism++;
                chk($sformatf("slot%0d payload", s), mism, 0);
            end
        end
        chk("oob writes", oob_writes, 0);

        // Reset in the middle of a packet.
        do_reset();
        send_word(16'hAAAA, 1'b1, 1'b0);
        send_word(16'hBBBB, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst ready", in_ready, 0);
        chk("midrst mem_write", mem_write, 0);
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(1);
        wlog.delete();
        send_word(16'hCCCC, 1'b0, 1'b0);
        send_word(16'hDDDD, 1'b0, 1'b1);
        send_word(16'hBEEF, 1'b1, 1'b1);
        wait_cycles(5);
        chk("midrst fill", fill_count, 1);
        chk("midrst writes", wlog.size(), 2);
        chk("midrst payload", tbmem[15'h4001], 16'hBEEF);
        chk("midrst header", tbmem[15'h4000], 16'h0001);

        // Release with an empty ring, then release alongside a commit.
        do_reset();
        pulse_rel();
        wait_cycles(3);
        chk("rel at empty", fill_count, 0);
        pkt[0] = 16'h0042; pkt[1] = 16'h0043;
        for (int k = 0; k < 3; k++) begin send_pkt(2); wait_cycles(4); end
        chk("fill before collide", fill_count, 3);
        send_pkt(2);
        wait_cycles(1);
        chk("collide hdr on bus", {mem_write, mem_address}, {1'b1, 15'h4060});
        pulse_rel();
        wait_cycles(4);
        chk("commit+rel fill", fill_count, 3);
        pulse_rel();
        wait_cycles(3);
        chk("rel alone fill", fill_count, 2);

        // Randomized traffic against a slot-count model.
        do_reset();
        gap_en = 1'b1;
        m_fill = 0; m_drop = 0; m_slot = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                pulse_rel();
                wait_cycles(3);
                if (m_fill > 0) m_fill--;
            end else begin
                if ($urandom_range(0, 4) == 0) send_word(16'($urandom), 1'b0, 1'($urandom));
                n = $urandom_range(1, 40);
                for (int i = 0; i < n; i++) pkt[i] = 16'($urandom);
                idx = wlog.size();
                send_pkt(n);
                wait_cycles(4);
                if (m_fill < 8) begin
                    stored = (n < 31) ? n : 31;
                    base = 16'h4000 + m_slot * 32;
                    hdr = 16'(stored);
                    if (n > 31) hdr[15] = 1'b1;
                    chk("rnd writes", wlog.size() - idx, stored + 1);
                    chk("rnd header", tbmem[base], hdr);
                    mism = 0;
                    for (int i = 0; i < stored; i++) if (tbmem[base + 1 + i] !== pkt[i]) mism++;
                    chk("rnd payload", mism, 0);
                    m_slot = (m_slot + 1) % 8;
                    m_fill++;
                end else begin
                    chk("rnd drop writes", wlog.size() - idx, 0);
                    if (m_drop < 65535) m_drop++;
                end
            end
            chk("rnd fill", fill_count, m_fill);
            chk("rnd drop", drop_count, m_drop);
`ifdef DIRCC_MSG_RX_IRQ_EN
            chk("rnd irq", irq, m_fill != 0);
`endif
        end
        gap_en = 1'b0;

        chk("strobe consistency", bad_strobe, 0);
        chk("oob writes final", oob_writes, 0);
`ifndef DIRCC_MSG_RX_IRQ_EN
        chk("irq tied low", irq_seen, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dircc_msg_rx_dma.md
DIRCC_MSG_RX_DMA -- requirements
Module: dircc_msg_rx_dma

Interface
REQ-001 Parameter BASE_ADDR, default 15'h4000: first 16-bit word address of the receive ring, on the 16-bit port (port 2) of the node processing memory.
REQ-002 Parameter SLOT_WORDS, default 32: 16-bit words per slot; power of two, 4..256.
REQ-003 Parameter NUM_SLOTS, default 8: slots in the ring; power of two, 2..16.
REQ-004 clk  input  1  single clock; all logic is on rising edge.
REQ-005 reset_n  input  1  asynchronous assert, active-low reset.
REQ-006 in_valid / in_ready  input / output  1 / 1  packet stream handshake; a word transfers when both are high.
REQ-007 in_data  input  16  payload word.
REQ-008 in_sop / in_eop  input  1 / 1  first / last word of a packet; both high marks a one-word packet.
REQ-009 mem_address  output  15  word address to processing memory port 2.
REQ-010 mem_chipselect, mem_write, mem_clken  output  1 each  write strobe; all three high for exactly the write cycle.
REQ-011 mem_writedata / mem_byteenable  output  16 / 2  write data; byteenable is always 2'b11.
REQ-012 rel  input  1  one-cycle pulse from CPU: oldest full slot has been consumed.
REQ-013 fill_count  output  5  number of full slots.
REQ-014 drop_count  output  16  packets dropped for lack of a slot; saturates at 16'hFFFF.
REQ-015 irq  output  1  receive interrupt (see Configuration).

Function
REQ-016 Slot k base address SHALL be BASE_ADDR + k*SLOT_WORDS, modulo 2^15. Word 0 holds the header; words 1..SLOT_WORDS-1 hold payload.
REQ-017 Header SHALL be {trunc[15], 7'b0, len[7:0]}. len is the number of payload words stored.
REQ-018 FSM states SHALL be IDLE, PAYLOAD, HEADER and DROP.
REQ-019 IDLE: in_ready=1. sop with fill_count<NUM_SLOTS -> write the word to base+1 and go to PAYLOAD, or to HEADER if eop is also set. sop with the ring full -> drop_count+1 and go to DROP, or stay in IDLE if eop is also set. A word without sop SHALL be discarded.
REQ-020 PAYLOAD: in_ready=1; each accepted word is written to the next address. eop -> HEADER. Acceptance of word SLOT_WORDS-1 without eop -> set trunc and go to DROP.
REQ-021 DROP: in_ready=1; words are discarded until eop. Exit goes to HEADER if trunc is set, otherwise to IDLE.
REQ-022 HEADER: in_ready=0 for one cycle; write the header, advance the write slot modulo NUM_SLOTS, clear trunc, then go to IDLE.
REQ-023 mem_* outputs SHALL be registered. A word accepted in cycle N appears on the memory bus in cycle N+1. After eop in cycle N, the header appears in cycle N+2 and fill_count increments in cycle N+3.
REQ-024 A commit and a rel in the same cycle SHALL leave fill_count unchanged. rel with fill_count=0 SHALL be ignored. fill_count SHALL never exceed NUM_SLOTS.
REQ-025 Back-to-back packets SHALL be accepted with exactly one bubble cycle (the HEADER state) between them.

Reset
REQ-026 Reset SHALL return the FSM to IDLE and clear the write slot, trunc, fill_count, drop_count, irq and all mem_* strobes to 0. in_ready SHALL be 0 during reset.
REQ-027 A packet in flight when reset asserts SHALL be abandoned and its slot not committed. After reset, the remainder of that packet is discarded under the no-sop rule.

Configuration
REQ-028 Macro DIRCC_MSG_RX_IRQ_EN. When defined: irq is a registered level, high while fill_count != 0. When undefined: irq is tied to 0 and no irq logic is built. All other behaviour is identical either way.

Structure
REQ-029 Package dircc_msg_pkg SHALL hold the FSM state enum, header bit positions (HDR_TRUNC_BIT=15, HDR_LEN_MSB=7) and parameter defaults.
REQ-030 Sub-module dircc_msg_slot_ring SHALL contain the write-slot pointer, fill_count and the commit/rel arbitration.

Verification
REQ-031 Scenario: 3-word packet 0x1111, 0x2222, 0x3333 at reset defaults -> writes to 0x4001..0x4003, then header 0x0003 to 0x4000, then fill_count=1.
REQ-032 Scenario: 40-word packet, SLOT_WORDS=32 -> 31 payload writes, header 0x801F, remaining 9 words consumed with in_ready=1.
REQ-033 Scenario: 9 packets with no rel -> slots 0..7 filled, 9th dropped, drop_count=1, fill_count=8, no write beyond 0x40FF.
REQ-034 Scenario: commit and rel in the same cycle at fill_count=3 -> fill_count stays 3. rel at fill_count=0 -> stays 0.
REQ-035 Scenario: reset_n low mid-packet after 2 words, released, then the rest of that packet followed by a new 1-word packet -> old words discarded, new packet lands in slot 0 with header 0x0001.
REQ-036 Scenario: irq, built with and without DIRCC_MSG_RX_IRQ_EN -> irq rises the cycle after fill_count becomes 1 only when defined; constant 0 otherwise.
